lane_serial_scheduler: RTL and testbench

LANE_SERIAL_SCHEDULER -- requirements
Module: lane_serial_scheduler

---
 rtl/lane_serial_scheduler.sv | 129 ++++++++++++
 tb/tb_lane_serial_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lane_serial_scheduler.sv
// Serializes a captured 4-lane byte frame onto one output, one slot per transfer.
// Build option LANE_SKIP_INVALID_EN: emit only lanes whose captured valid bit is set.
module lane_serial_scheduler (
    input  logic       clk_1,
    input  logic       reset,
    input  logic [7:0] dataIn0,
    input  logic [7:0] dataIn1,
    input  logic [7:0] dataIn2,
    input  logic [7:0] dataIn3,
    input  logic       validIn0,
    input  logic       validIn1,
    input  logic       validIn2,
    input  logic       validIn3,
    input  logic       out_ready,
    output logic       in_ready,
    output logic [7:0] dataOut,
    output logic       validOut,
    output logic       selector0,
    output logic       selector1,
    output logic [7:0] frame_cnt
);

    typedef enum logic [0:0] {StIdle, StSend} stateT;

    stateT           stateQ, stateD;
    logic [3:0][7:0] holdDataQ, holdDataD;
    logic [3:0]      maskQ, maskD;
    logic [1:0]      slotQ, slotD;
    logic [7:0]      dataOutQ, dataOutD;
    logic            validOutQ, validOutD;
    logic [7:0]      frameCntQ, frameCntD;

    logic [3:0][7:0] inLanes;
    logic [3:0]      inMask;
    logic            lastSlot;
    logic [1:0]      nextSlot;
    logic [1:0]      firstSlot;
    logic            accept;

    assign inLanes = {dataIn3, dataIn2, dataIn1, dataIn0};
    assign inMask  = {validIn3, validIn2, validIn1, validIn0};

`ifdef LANE_SKIP_INVALID_EN
    logic [3:0] aboveMask;

    function automatic logic [1:0] lowestLane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Valid lanes strictly above the current slot decide where the frame goes next.
    always_comb begin
        aboveMask = maskQ & (4'b1110 << slotQ);
        lastSlot  = (aboveMask == 4'b0000);
        nextSlot  = lowestLane(aboveMask);
        firstSlot = lowestLane(inMask);
    end
`else
    always_comb begin
        lastSlot  = (slotQ == 2'd3);
        nextSlot  = slotQ + 2'd1;
        firstSlot = 2'd0;
    end
`endif

    assign in_ready = (stateQ == StIdle) || (lastSlot && out_ready);
    assign accept   = in_ready && (inMask != 4'b0000);

    always_comb begin
        stateD    = stateQ;
        holdDataD = holdDataQ;
        maskD     = maskQ;
        slotD     = slotQ;
        dataOutD  = dataOutQ;
        validOutD = validOutQ;
        frameCntD = frameCntQ;

        if (accept) begin
            // Covers both the IDLE accept and the back-to-back reload on the last slot.
            stateD    = StSend;
            holdDataD = inLanes;
            maskD     = inMask;
            slotD     = firstSlot;
            dataOutD  = inMask[firstSlot] ? inLanes[firstSlot] : 8'h00;
            validOutD = inMask[firstSlot];
            frameCntD = frameCntQ + 8'd1;
        end else if (stateQ == StSend && out_ready) begin
            if (lastSlot) begin
                stateD    = StIdle;
                slotD     = 2'd0;
                dataOutD  = 8'h00;
                validOutD = 1'b0;
            end else begin
                slotD     = nextSlot;
                dataOutD  = maskQ[nextSlot] ? holdDataQ[nextSlot] : 8'h00;
                validOutD = maskQ[nextSlot];
            end
        end
    end

    always_ff @(posedge clk_1 or posedge reset) begin
        if (reset) begin
            stateQ    <= StIdle;
            holdDataQ <= '0;
            maskQ     <= '0;
            slotQ     <= 2'd0;
            dataOutQ  <= 8'h00;
            validOutQ <= 1'b0;
            frameCntQ <= 8'h00;
        end else begin
            stateQ    <= stateD;
            holdDataQ <= holdDataD;
            maskQ     <= maskD;
            slotQ     <= slotD;
            dataOutQ  <= dataOutD;
            validOutQ <= validOutD;
            frameCntQ <= frameCntD;
        end
    end

    assign dataOut   = dataOutQ;
    assign validOut  = validOutQ;
    assign selector0 = slotQ[1];
    assign selector1 = slotQ[0];
    assign frame_cnt = frameCntQ;

endmodule

// File: tb/tb_lane_serial_scheduler.sv
// Randomized bench for lane_serial_scheduler against a queue-of-pending-slots model.
// Honours LANE_SKIP_INVALID_EN the same way the design does.
module tb_lane_serial_scheduler;

    logic       clk_1 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din [4];
    logic [3:0] vin;
    logic       outReady;
    logic       in_ready;
    logic [7:0] dataOut;
    logic       validOut;
    logic       selector0;
    logic       selector1;
    logic [7:0] frame_cnt;

    typedef struct packed {
        logic [1:0] lane;
        logic [7:0] data;
        logic       valid;
    } slotT;

    slotT       pending [$];
    logic [7:0] modelCnt;
    int         acceptCount;
    int         checks = 0;
    int         errors = 0;

    lane_serial_scheduler dut (
        .clk_1     (clk_1),
        .reset     (reset),
        .dataIn0   (din[0]),
        .dataIn1   (din[1]),
        .dataIn2   (din[2]),
        .dataIn3   (din[3]),
        .validIn0  (vin[0]),
        .validIn1  (vin[1]),
        .validIn2  (vin[2]),
        .validIn3  (vin[3]),
        .out_ready (outReady),
        .in_ready  (in_ready),
        .dataOut   (dataOut),
        .validOut  (validOut),
        .selector0 (selector0),
        .selector1 (selector1),
        .frame_cnt (frame_cnt)
    );

    always #5 clk_1 = ~clk_1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic setFrame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [7:0] d3, input logic [3:0] v);
        din[0] = d0;
        din[1] = d1;
        din[2] = d2;
        din[3] = d3;
        vin    = v;
    endtask

    task automatic pushFrame();
        for (int i = 0; i < 4; i++) begin
`ifdef LANE_SKIP_INVALID_EN
            if (vin[i]) pending.push_back('{lane: 2'(i), data: din[i], valid: 1'b1});
`else
            pending.push_back('{lane: 2'(i), data: (vin[i] ? din[i] : 8'h00), valid: vin[i]});
`endif
        end
    endtask

    // Compare current outputs with the model, then advance model and DUT by one edge.
    task automatic tick();
        logic       expReady;
        logic [7:0] expData;
        logic       expValid;
        logic [1:0] expSel;
        #1;
        if (pending.size() > 0) begin
            expData  = pending[0].data;
            expValid = pending[0].valid;
            expSel   = pending[0].lane;
        end else begin
            expData  = 8'h00;
            expValid = 1'b0;
            expSel   = 2'd0;
        end
        expReady = (pending.size() == 0) || (pending.size() == 1 && outReady);
        checkVal("dataOut", 32'(dataOut), 32'(expData));
        checkVal("validOut", 32'(validOut), 32'(expValid));
        checkVal("selector", 32'({selector0, selector1}), 32'(expSel));
        checkVal("in_ready", 32'(in_ready), 32'(expReady));
        checkVal("frame_cnt", 32'(frame_cnt), 32'(modelCnt));
        if (outReady && pending.size() > 0) void'(pending.pop_front());
        if (expReady && vin != 4'b0000) begin
            pushFrame();
            modelCnt = modelCnt + 8'd1;
            acceptCount++;
        end
        @(posedge clk_1);
        #1;
    endtask

    task automatic midReset();
        reset = 1'b1;
        #1;
        checkVal("rst_dataOut", 32'(dataOut), 32'h0);
        checkVal("rst_validOut", 32'(validOut), 32'h0);
        checkVal("rst_selector", 32'({selector0, selector1}), 32'h0);
        checkVal("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        checkVal("rst_in_ready", 32'(in_ready), 32'h1);
        pending.delete();
        modelCnt = 8'h00;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        modelCnt    = 8'h00;
        acceptCount = 0;
        outReady    = 1'b1;
        setFrame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        #2;
        midReset();
        @(posedge clk_1);
        #1;

        // Full frame, then back-to-back frame offered on the last slot.
        setFrame(8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'b1111);
        tick();
        setFrame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        tick(); tick(); tick();
        setFrame(8'hBB, 8'hAA, 8'h99, 8'h88, 4'b1111);
        tick();
        setFrame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        tick(); tick(); tick(); tick(); tick();

        // Only lane 2 valid.
        setFrame(8'h11, 8'h22, 8'h77, 8'h33, 4'b0100);
        tick();
        setFrame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        for (int i = 0; i < 5; i++) tick();

        // Stall on the EE slot while mid-frame inputs wiggle.
        setFrame(8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'b1111);
        tick();
        setFrame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        tick();
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setFrame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'b1111);
            tick();
        end
        outReady = 1'b1;
        setFrame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        tick();

        // Reset while DD is on the output.
        midReset();
        tick(); tick();

        // 256 single-lane accepts wrap the counter.
        acceptCount = 0;
        setFrame(8'h5A, 8'h00, 8'h00, 8'h00, 4'b0001);
        for (int i = 0; i < 2000 && acceptCount < 256; i++) tick();
        setFrame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        for (int i = 0; i < 5; i++) tick();
        checkVal("wrap_accepts", 32'(acceptCount), 32'd256);
        checkVal("wrap_frame_cnt", 32'(frame_cnt), 32'h0);

        // All-invalid presentation in IDLE.
        setFrame(8'h12, 8'h34, 8'h56, 8'h78, 4'b0000);
        tick(); tick();
        checkVal("noaccept_frame_cnt", 32'(frame_cnt), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            setFrame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom));
            outReady = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
